// File: rtl/ttr_vote_w.sv
// Triple-time-redundancy capture stage: three consecutive copies of each sample form a frame
// and are majority-voted into a held output register. A bypass mode makes it a plain register.
module ttr_vote_w #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             sync,
    input  logic             bypass,
    input  logic             clr_err,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    output logic             mism,
    output logic             locked,
    output logic [CNT_W-1:0] err_cnt
);

    logic [1:0]       p;
    logic [1:0]       ph;
    logic [1:0]       pNext;
    logic [WIDTH-1:0] c1;
    logic [WIDTH-1:0] c2;
    logic             ok;
    logic             okNext;
    logic             voteEn;
    logic             diff;
    logic [WIDTH-1:0] voted;
    logic [CNT_W-1:0] cntNext;

    always_comb begin
        ph      = sync ? 2'd0 : p;
        pNext   = (ph == 2'd2) ? 2'd0 : ph + 2'd1;
        voteEn  = !bypass && ok && locked && (ph == 2'd2);
        voted   = (c1 & c2) | (c1 & din) | (c2 & din);
        diff    = |((c1 ^ c2) | (c2 ^ din));
        // A frame stays eligible only if none of its cycles saw bypass.
        okNext  = ok;
        if (bypass)
            okNext = 1'b0;
        else if (ph == 2'd0)
            okNext = 1'b1;
        cntNext = err_cnt;
        if (clr_err)
            cntNext = '0;
        else if (voteEn && diff && (err_cnt != {CNT_W{1'b1}}))
            cntNext = err_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p        <= 2'd0;
            locked   <= 1'b0;
            c1       <= '0;
            c2       <= '0;
            ok       <= 1'b0;
            dout     <= '0;
            dout_vld <= 1'b0;
            mism     <= 1'b0;
            err_cnt  <= '0;
        end else begin
            p        <= pNext;
            ok       <= okNext;
            err_cnt  <= cntNext;
            dout_vld <= bypass || voteEn;
            mism     <= voteEn && diff;
            if (sync)
                locked <= 1'b1;
            if (ph == 2'd0)
                c1 <= din;
            if (ph == 2'd1)
                c2 <= din;
            if (bypass)
                dout <= din;
            else if (voteEn)
                dout <= voted;
        end
    end

endmodule

// File: tb/tb_ttr_vote_w.sv
// Self-checking bench for ttr_vote_w: directed scenarios plus randomized traffic compared
// against a frame-level reference model (per-bit vote counting over recorded copies).
module tb_ttr_vote_w;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       sync;
    logic       bypass;
    logic       clr_err;
    logic [7:0] dout;
    logic       dout_vld;
    logic       mism;
    logic       locked;
    logic [3:0] err_cnt;

    int checks = 0;
    int failures = 0;

    // reference model state
    int         mP;
    bit         mLocked;
    bit         mAll;
    logic [7:0] fr [3];
    logic [7:0] expDout;
    logic       expVld;
    logic       expMism;
    logic       expLocked;
    logic [3:0] expCnt;

    ttr_vote_w #(.WIDTH(8), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .din(din), .sync(sync), .bypass(bypass), .clr_err(clr_err),
        .dout(dout), .dout_vld(dout_vld), .mism(mism), .locked(locked), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic modelReset();
        mP = 0; mLocked = 0; mAll = 0;
        for (int j = 0; j < 3; j++) fr[j] = 8'h00;
        expDout = 8'h00; expVld = 0; expMism = 0; expLocked = 0; expCnt = 4'h0;
    endtask

    task automatic doReset();
        sync = 0; bypass = 0; clr_err = 0; din = 8'h00;
        rst = 1;
        modelReset();
        @(posedge clk); #1;
        rst = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then sample just after the edge.
    task automatic tick(input logic s, input logic b, input logic c, input logic [7:0] d);
        int ph;
        int n;
        bit vote;
        sync = s; bypass = b; clr_err = c; din = d;
        ph = s ? 0 : mP;
        vote = 0;
        if (ph == 0) begin
            fr[0] = d; mAll = !b;
        end else if (ph == 1) begin
            fr[1] = d; mAll = mAll && !b;
        end else begin
            fr[2] = d; vote = mAll && !b && mLocked;
        end
        expVld = 0; expMism = 0;
        if (b) begin
            expDout = d; expVld = 1;
        end else if (vote) begin
            for (int i = 0; i < 8; i++) begin
                n = 0;
                for (int j = 0; j < 3; j++) if (fr[j][i]) n++;
                expDout[i] = (n >= 2);
            end
            expVld = 1;
            expMism = !((fr[0] == fr[1]) && (fr[1] == fr[2]));
        end
        if (c) expCnt = 4'h0;
        else if (expMism && expCnt != 4'hF) expCnt = expCnt + 4'd1;
        if (s) mLocked = 1;
        expLocked = mLocked;
        mP = (ph == 2) ? 0 : ph + 1;
        @(posedge clk); #1;
    endtask

    task automatic frame(input logic s, input logic [7:0] a, input logic [7:0] b2,
                         input logic [7:0] c3);
        tick(s, 0, 0, a);
        tick(0, 0, 0, b2);
        tick(0, 0, 0, c3);
    endtask

    task automatic test_reset();
        rst = 1;
        modelReset();
        #3;
        checks++;
        if ({dout, dout_vld, mism, locked, err_cnt} !== 15'h0) begin
            failures++;
            $display("FAIL reset_values got=%h required=0", {dout, dout_vld, mism, locked, err_cnt});
        end
        doReset();
        tick(0, 0, 0, 8'h3C);
        checks++;
        if ({dout_vld, locked} !== 2'b00) begin
            failures++;
            $display("FAIL reset_nosync got vld/locked=%b required=00", {dout_vld, locked});
        end
    endtask

    task automatic test_basic();
        doReset();
        for (int k = 0; k < 5; k++) begin
            tick(k == 0, 0, 0, 8'hA5);
            checks++;
            if ({dout, dout_vld, mism, locked, err_cnt} !== {expDout, expVld, expMism, expLocked, expCnt}) begin
                failures++;
                $display("FAIL basic_cycle%0d got=%h required=%h", k + 1,
                         {dout, dout_vld, mism, locked, err_cnt}, {expDout, expVld, expMism, expLocked, expCnt});
            end
            if (k == 2) begin
                checks++;
                if ({dout, dout_vld, mism, locked, err_cnt} !== {8'hA5, 1'b1, 1'b0, 1'b1, 4'h0}) begin
                    failures++;
                    $display("FAIL basic_vote got=%h required=%h",
                             {dout, dout_vld, mism, locked, err_cnt}, {8'hA5, 1'b1, 1'b0, 1'b1, 4'h0});
                end
            end
        end
    endtask

    task automatic test_correction();
        doReset();
        frame(1, 8'hA5, 8'hA4, 8'hA5);
        checks++;
        if ({dout, dout_vld, mism, err_cnt} !== {8'hA5, 1'b1, 1'b1, 4'h1}) begin
            failures++;
            $display("FAIL single_copy got=%h required=%h", {dout, dout_vld, mism, err_cnt}, {8'hA5, 1'b1, 1'b1, 4'h1});
        end
        frame(1, 8'h0F, 8'hF0, 8'hFF);
        checks++;
        if ({dout, dout_vld, mism, err_cnt} !== {8'hFF, 1'b1, 1'b1, 4'h2}) begin
            failures++;
            $display("FAIL bitwise got=%h required=%h", {dout, dout_vld, mism, err_cnt}, {8'hFF, 1'b1, 1'b1, 4'h2});
        end
    endtask

    task automatic test_saturation();
        logic [7:0] a;
        doReset();
        for (int f = 0; f < 20; f++) begin
            a = 8'($urandom);
            frame(f == 0, a, a ^ 8'($urandom_range(1, 255)), a);
            checks++;
            if ({dout, dout_vld, mism, err_cnt} !== {expDout, expVld, expMism, expCnt}) begin
                failures++;
                $display("FAIL sat_frame%0d got=%h required=%h", f,
                         {dout, dout_vld, mism, err_cnt}, {expDout, expVld, expMism, expCnt});
            end
        end
        checks++;
        if (err_cnt !== 4'hF) begin
            failures++;
            $display("FAIL sat_limit got=%0d required=15", err_cnt);
        end
        tick(0, 0, 1, 8'h11);
        checks++;
        if (err_cnt !== 4'h0 || expCnt !== 4'h0) begin
            failures++;
            $display("FAIL clr_with_mism got=%0d required=0", err_cnt);
        end
    endtask

    task automatic test_abort();
        logic [7:0] z;
        doReset();
        z = 8'h5A ^ 8'($urandom_range(0, 255));
        frame(1, 8'h11, 8'h11, 8'h11);
        tick(0, 0, 0, 8'h22);
        tick(1, 0, 0, z);
        tick(0, 0, 0, z);
        checks++;
        if (dout_vld !== 1'b0 || dout_vld !== expVld) begin
            failures++;
            $display("FAIL abort_novld got=%b required=0", dout_vld);
        end
        tick(0, 0, 0, z);
        checks++;
        if ({dout, dout_vld, mism} !== {z, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL abort_revote got=%h required=%h", {dout, dout_vld, mism}, {z, 1'b1, 1'b0});
        end
        doReset();
        for (int k = 0; k < 10; k++) begin
            tick(0, 0, 0, 8'($urandom));
            checks++;
            if ({dout_vld, locked} !== 2'b00) begin
                failures++;
                $display("FAIL unlocked_cycle%0d got vld/locked=%b required=00", k, {dout_vld, locked});
            end
        end
    endtask

    task automatic test_bypass();
        logic [7:0] v;
        doReset();
        for (int k = 0; k < 12; k++) begin
            tick(k == 0, 1, 0, 8'(k));
            checks++;
            if ({dout, dout_vld, mism} !== {8'(k), 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL bypass_ramp%0d got=%h required=%h", k, {dout, dout_vld, mism}, {8'(k), 1'b1, 1'b0});
            end
        end
        tick(1, 1, 0, 8'h40);
        tick(0, 0, 0, 8'h41);
        tick(0, 0, 0, 8'h42);
        checks++;
        if ({dout, dout_vld} !== {8'h40, 1'b0}) begin
            failures++;
            $display("FAIL bypass_drop got=%h required=%h", {dout, dout_vld}, {8'h40, 1'b0});
        end
        v = 8'($urandom);
        frame(0, v, v, v);
        checks++;
        if ({dout, dout_vld, mism} !== {v, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL bypass_return got=%h required=%h", {dout, dout_vld, mism}, {v, 1'b1, 1'b0});
        end
    endtask

    task automatic test_async_reset();
        doReset();
        frame(1, 8'hC3, 8'hC2, 8'hC3);
        tick(0, 0, 0, 8'h77);
        #2 rst = 1;
        modelReset();
        #1;
        checks++;
        if ({dout, dout_vld, mism, locked, err_cnt} !== 15'h0) begin
            failures++;
            $display("FAIL async_reset got=%h required=0", {dout, dout_vld, mism, locked, err_cnt});
        end
        #2 rst = 0;
        for (int k = 0; k < 6; k++) begin
            tick(0, 0, 0, 8'h77);
            checks++;
            if ({dout_vld, locked} !== 2'b00) begin
                failures++;
                $display("FAIL post_reset%0d got vld/locked=%b required=00", k, {dout_vld, locked});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] base;
        logic       s;
        logic       b;
        doReset();
        base = 8'h00;
        b = 0;
        for (int k = 0; k < 600; k++) begin
            s = (k == 0) || ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) b = !b;
            if (s || mP == 0) base = 8'($urandom);
            tick(s, b, $urandom_range(0, 24) == 0,
                 base ^ (($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00));
            checks++;
            if ({dout, dout_vld, mism, locked, err_cnt} !== {expDout, expVld, expMism, expLocked, expCnt}) begin
                failures++;
                $display("FAIL random_cycle%0d got=%h required=%h", k,
                         {dout, dout_vld, mism, locked, err_cnt}, {expDout, expVld, expMism, expLocked, expCnt});
            end
        end
    endtask

    initial begin
        rst = 1; sync = 0; bypass = 0; clr_err = 0; din = 8'h00;
        #2;
        test_reset();
        test_basic();
        test_correction();
        test_saturation();
        test_abort();
        test_bypass();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
